cmsdk_apb4_eg_slave_if: RTL and testbench

APB4 slave-side protocol front end for the example slave. Sits directly upstream of the example-slave register bank. Converts APB4 transfers (psel/penable/pwrite/pstrb/pprot) into single-cycle addr/read_en/write_en/byte_strobe/wdata strobes for the bank. Inserts a parameterised number of wait states, registers read data and generates pslverr.

---
 rtl/cmsdk_apb4_eg_slave_pkg.sv | 18 +
 rtl/cmsdk_apb4_eg_slave_if.sv | 135 +++++++++++++
 tb/tb_cmsdk_apb4_eg_slave_if.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmsdk_apb4_eg_slave_pkg.sv
// Shared types and constants for the APB4 example-slave protocol front end.
// Nothing here is configurable; CMSDK_APB4_EG_SLAVE_PROT_CHECK_EN affects only the top.
package cmsdk_apb4_eg_slave_pkg;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;

  // Upper address bits of the read-only ID region for the default 12-bit bus.
  localparam logic [5:0] ID_PREFIX = 6'h3F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EXEC,
    DONE
  } state_e;

endpackage

// File: rtl/cmsdk_apb4_eg_slave_if.sv
// APB4 slave front end: turns APB transfers into one-cycle strobes for the register bank.
// Optional macro CMSDK_APB4_EG_SLAVE_PROT_CHECK_EN rejects unprivileged (pprot[0]=0) transfers.
module cmsdk_apb4_eg_slave_if
  import cmsdk_apb4_eg_slave_pkg::*;
#(
  parameter int ADDRWIDTH   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic [DATA_W-1:0]    pwdata,
  input  logic [3:0]           pstrb,
  input  logic [2:0]           pprot,
  output logic [DATA_W-1:0]    prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 read_en,
  output logic                 write_en,
  output logic [3:0]           byte_strobe,
  output logic [DATA_W-1:0]    wdata,
  input  logic [DATA_W-1:0]    rdata
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [3:0]             strb_q, strb_d;
  logic [DATA_W-1:0]      prdata_q, prdata_d;

  logic id_hit;
  logic req_err;
  logic unused_prot;

  generate
    if (ADDRWIDTH == 12) begin : g_id12
      assign id_hit = (paddr[11:6] == ID_PREFIX);
    end else begin : g_idn
      assign id_hit = &paddr[ADDRWIDTH-1:6];
    end
  endgenerate

`ifdef CMSDK_APB4_EG_SLAVE_PROT_CHECK_EN
  assign req_err     = (pwrite & id_hit) | ~pprot[0];
  assign unused_prot = ^pprot[2:1];
`else
  assign req_err     = pwrite & id_hit;
  assign unused_prot = ^pprot;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prdata_d = prdata_q;
    read_en  = 1'b0;
    write_en = 1'b0;
    pready   = 1'b0;
    pslverr  = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray penable is ignored.
        if (psel && !penable) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          strb_d  = pwrite ? pstrb : 4'b0000;
          wr_d    = pwrite;
          err_d   = req_err;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : EXEC;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = EXEC;
        end
      end
      EXEC: begin
        write_en = wr_q & ~err_q;
        read_en  = ~wr_q & ~err_q;
        prdata_d = read_en ? rdata : '0;
        state_d  = psel ? DONE : IDLE;
      end
      DONE: begin
        pready  = 1'b1;
        pslverr = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prdata      = prdata_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign byte_strobe = strb_q;

endmodule

// File: tb/tb_cmsdk_apb4_eg_slave_if.sv
// Randomised bench for cmsdk_apb4_eg_slave_if: three instances (0, 2, 3 wait states)
// share one APB master; a transaction-level model predicts every response.
module tb_cmsdk_apb4_eg_slave_if;

    localparam int AW = 12;
    localparam int N  = 3;
    localparam int WS_TAB [N] = '{0, 2, 3};

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic [N-1:0]  psel = '0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic [2:0]    pprot = '0;
    logic [31:0]   rd_val = '0;

    wire [31:0]    prdata_w [N];
    wire [N-1:0]   pready_w;
    wire [N-1:0]   pslverr_w;
    wire [AW-1:0]  addr_w [N];
    wire [N-1:0]   read_en_w;
    wire [N-1:0]   write_en_w;
    wire [3:0]     bs_w [N];
    wire [31:0]    wdata_w [N];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 pclk = ~pclk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            cmsdk_apb4_eg_slave_if #(
                .ADDRWIDTH(AW),
                .WAIT_STATES(WS_TAB[gi])
            ) u_dut (
                .pclk(pclk),
                .presetn(presetn),
                .psel(psel[gi]),
                .penable(penable),
                .pwrite(pwrite),
                .paddr(paddr),
                .pwdata(pwdata),
                .pstrb(pstrb),
                .pprot(pprot),
                .prdata(prdata_w[gi]),
                .pready(pready_w[gi]),
                .pslverr(pslverr_w[gi]),
                .addr(addr_w[gi]),
                .read_en(read_en_w[gi]),
                .write_en(write_en_w[gi]),
                .byte_strobe(bs_w[gi]),
                .wdata(wdata_w[gi]),
                .rdata(rd_val)
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer on instance d, checked against the model.
    task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] prot, input logic [31:0] rv,
                        output logic [31:0] prd_out);
        bit          exp_err;
        logic [31:0] exp_prd;
        int          cyc;
        int          nw;
        int          nr;
        int          scyc;
        exp_err = wr && (a >= 12'hFC0);
`ifdef CMSDK_APB4_EG_SLAVE_PROT_CHECK_EN
        if (!prot[0]) exp_err = 1'b1;
`endif
        exp_prd = (wr || exp_err) ? 32'h0 : rv;

        @(posedge pclk); #1;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        pprot   = prot;
        rd_val  = rv;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1; nw = 0; nr = 0; scyc = 0;
        while (1) begin
            if (write_en_w[d]) begin
                nw++; scyc = cyc;
                chk("wr_addr", 32'(addr_w[d]), 32'(a));
                chk("wr_bs", 32'(bs_w[d]), 32'(st));
                chk("wr_data", wdata_w[d], wd);
            end
            if (read_en_w[d]) begin
                nr++; scyc = cyc;
                chk("rd_addr", 32'(addr_w[d]), 32'(a));
                chk("rd_bs", 32'(bs_w[d]), 32'h0);
            end
            if (pready_w[d] || cyc >= 40) break;
            @(posedge pclk); #1;
            cyc++;
        end
        chk("pready", 32'(pready_w[d]), 32'h1);
        chk("latency", 32'(cyc), 32'(WS_TAB[d] + 2));
        chk("pslverr", 32'(pslverr_w[d]), 32'(exp_err));
        chk("prdata", prdata_w[d], exp_prd);
        chk("n_write", 32'(nw), 32'(wr && !exp_err));
        chk("n_read", 32'(nr), 32'(!wr && !exp_err));
        if (!exp_err) chk("strobe_cyc", 32'(scyc), 32'(WS_TAB[d] + 1));
        chk("addr_hold", 32'(addr_w[d]), 32'(a));
        chk("bs_hold", 32'(bs_w[d]), wr ? 32'(st) : 32'h0);
        $display("xfer dut=%0d ws=%0d wr=%0d addr=%h wd=%h st=%b prot=%b err=%0d prdata=%h cyc=%0d",
                 d, WS_TAB[d], wr, a, wd, st, prot, exp_err, prdata_w[d], cyc);
        prd_out = exp_prd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
            psel    = '0;
            penable = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] prd;
        int          nw;
        int          np;
        bit          wr;
        int          d;
        logic [AW-1:0] a;

        repeat (2) @(posedge pclk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_prdata", prdata_w[i], 32'h0);
            chk("rst_pready", 32'(pready_w[i]), 32'h0);
            chk("rst_strobes", 32'({read_en_w[i], write_en_w[i], pslverr_w[i]}), 32'h0);
            chk("rst_addr", 32'(addr_w[i]), 32'h0);
        end
        @(negedge pclk);
        presetn = 1'b1;

        // Directed cases from the plan.
        xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'b0101, 3'b001, 32'h0, prd);
        xfer(2, 1'b0, 12'h008, 32'h0, 4'b0000, 3'b001, 32'h12345678, prd);
        idle(1);
        xfer(0, 1'b0, 12'h010, 32'h0, 4'b1111, 3'b001, 32'hCAFEF00D, prd);
        xfer(0, 1'b1, 12'hFE0, 32'h55AA55AA, 4'b1111, 3'b001, 32'h0BADBEEF, prd);
        idle(1);
        xfer(0, 1'b1, 12'h000, 32'h01020304, 4'b1111, 3'b001, 32'h0, prd);
        xfer(0, 1'b0, 12'h000, 32'h0, 4'b0000, 3'b001, 32'hA5A5A5A5, prd);
        xfer(2, 1'b1, 12'hFFC, 32'h11111111, 4'b0011, 3'b001, 32'h0, prd);

        // Abort on the 2-wait-state instance: psel falls during WAIT.
        xfer(1, 1'b0, 12'h024, 32'h0, 4'b0000, 3'b001, 32'h89ABCDEF, prd);
        @(posedge pclk); #1;
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030;
        pwdata = 32'h77777777; pstrb = 4'b1111; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        psel = '0;
        nw = 0; np = 0;
        repeat (6) begin
            @(posedge pclk); #1;
            penable = 1'b0;
            if (write_en_w[1]) nw++;
            if (pready_w[1]) np++;
        end
        chk("abort_write_en", 32'(nw), 32'h0);
        chk("abort_pready", 32'(np), 32'h0);
        chk("abort_prdata", prdata_w[1], 32'h89ABCDEF);
        $display("xfer dut=1 aborted write addr=030");

        // Reset asserted on entry to EXEC of the next write.
        @(posedge pclk); #1;
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 12'h034;
        pwdata = 32'h99999999; pstrb = 4'b1010;
        @(posedge pclk); #1;
        penable = 1'b1;
        chk("pre_rst_write_en", 32'(write_en_w[1]), 32'h0);
        @(posedge pclk); #1;
        chk("pre_rst_write_en", 32'(write_en_w[1]), 32'h0);
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        chk("midrst_write_en", 32'(write_en_w[1]), 32'h0);
        chk("midrst_read_en", 32'(read_en_w[1]), 32'h0);
        chk("midrst_pready", 32'({pready_w[1], pslverr_w[1]}), 32'h0);
        chk("midrst_prdata", prdata_w[1], 32'h0);
        chk("midrst_addr", 32'(addr_w[1]), 32'h0);
        chk("midrst_wdata", wdata_w[1], 32'h0);
        chk("midrst_bs", 32'(bs_w[1]), 32'h0);
        $display("xfer dut=1 reset during EXEC addr=034");
        @(negedge pclk);
        psel = '0; penable = 1'b0;
        presetn = 1'b1;

`ifdef CMSDK_APB4_EG_SLAVE_PROT_CHECK_EN
        xfer(0, 1'b0, 12'h000, 32'h0, 4'b0000, 3'b000, 32'h13572468, prd);
        xfer(0, 1'b0, 12'h000, 32'h0, 4'b0000, 3'b001, 32'h13572468, prd);
`endif

        // Randomised traffic across all three instances.
        for (int t = 0; t < 60; t++) begin
            d  = int'($urandom_range(0, N - 1));
            wr = 1'($urandom);
            a  = AW'($urandom);
            if ($urandom_range(0, 3) == 0) a = 12'hFC0 | AW'($urandom_range(0, 63));
            xfer(d, wr, a, $urandom, 4'($urandom), 3'($urandom), $urandom, prd);
            if ($urandom_range(0, 1) == 1) begin
                idle(int'($urandom_range(1, 2)));
                chk("prdata_hold", prdata_w[d], prd);
            end
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
